// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame geometry, deframer state encoding, common scan codes.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam logic [7:0] BREAK_F0 = 8'hF0;
  localparam logic [7:0] EXT_E0   = 8'hE0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // A frame is good when the stop bit is high and data plus parity carry odd parity.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] data,
                                    input logic parity,
                                    input logic stop);
    return stop && (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO with wrap-bit pointers; a push into a full FIFO is accepted only alongside a pop.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_write;
  logic        do_read;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_read  = pop && !empty;
  assign do_write = push && (!full || do_read);
  assign dout     = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_read)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // When full, the write lands in the slot the simultaneous pop is vacating.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the pad lines, deframes scan codes and queues them for bus reads.
// Define PS2_FRAME_CHECK_EN to discard frames with a bad stop bit or even parity.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rdn,
  output logic       ready,
  output logic [7:0] key_data,
  output logic       overflow
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall_edge;
  logic                   bit_in;

  logic [1:0]             state;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [2:0]             bit_cnt;
  logic [WD_W-1:0]        wd_cnt;

  logic                   io_rdn_q;
  logic                   push_req;
  logic                   pop_req;
  logic                   frame_good;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign fall_edge = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in    = data_sync[SYNC_STAGES-1];

  // Sync chains reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

`ifdef PS2_FRAME_CHECK_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
    end else if (fall_edge && state == ST_PARITY) begin
      parity_bit <= bit_in;
    end
  end

  assign frame_good = frame_ok(shift_reg, parity_bit, bit_in);
`else
  assign frame_good = 1'b1;
`endif

  assign push_req = fall_edge && (state == ST_STOP) && frame_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      wd_cnt    <= '0;
    end else begin
      if (state == ST_IDLE || fall_edge) wd_cnt <= '0;
      else                               wd_cnt <= wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};

      case (state)
        ST_IDLE: begin
          if (fall_edge && !bit_in) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (fall_edge) begin
            shift_reg <= {bit_in, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= ST_PARITY;
          end
        end
        ST_PARITY: if (fall_edge) state <= ST_STOP;
        ST_STOP:   if (fall_edge) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      // A stalled frame is abandoned so the next start bit is found cleanly.
      if (state != ST_IDLE && !fall_edge && wd_cnt == WD_LAST) state <= ST_IDLE;
    end
  end

  assign pop_req = io_rdn & ~io_rdn_q & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdn_q <= 1'b1;
      overflow <= 1'b0;
    end else begin
      io_rdn_q <= io_rdn;
      if (push_req && fifo_full && !pop_req) overflow <= 1'b1;
    end
  end

  ps2_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop_req),
    .din   (shift_reg),
    .dout  (key_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = ~fifo_empty;

endmodule
